vc_circular_buffer: RTL and testbench

- Input-port flit storage with VC_NUM independent circular FIFOs, one per virtual channel, each BUFFER_SIZE flits deep.
- The writer selects the VC from data_i.vc_id; the reader selects it via read_vc_i.
- Generalises the single-queue circular_buffer: per-VC depth, occupancy, an almost-full threshold for upstream credit/backpressure logic, and sticky overflow/underflow error flags.
- Sits between the link input and the VC allocator/crossbar read side in input_port.

---
 rtl/vc_circular_buffer_pkg.sv | 23 ++
 rtl/vc_circular_buffer.sv | 173 +++++++++++++++++
 tb/tb_vc_circular_buffer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_circular_buffer_pkg.sv
// ---------------------------------------------------------------------------
// vc_circular_buffer_pkg
//   Flit format shared by the per-VC input buffer and its neighbours.
//   A flit carries:
//     flit_label : head/body/tail marking used by the allocators
//     vc_id      : virtual channel the flit travels on.
//                  The field is wider than the VC index so that an
//                  out-of-range VC can be represented and rejected.
//     head_data  : payload byte
// ---------------------------------------------------------------------------
package vc_circular_buffer_pkg;

  localparam int VC_ID_W = 2;
  localparam int LABEL_W = 2;
  localparam int DATA_W  = 8;

  typedef struct packed {
    logic [LABEL_W-1:0] flit_label;
    logic [VC_ID_W-1:0] vc_id;
    logic [DATA_W-1:0]  head_data;
  } flit_t;

endpackage

// File: rtl/vc_circular_buffer.sv
// ---------------------------------------------------------------------------
// vc_circular_buffer
//   Input-port flit storage: VC_NUM independent circular FIFOs, one per
//   virtual channel, each BUFFER_SIZE flits deep.
//   The writer picks the VC from data_i.vc_id. The reader picks it with
//   read_vc_i. The head of the selected VC is shown combinationally on
//   data_o (first-word fall-through).
//
// Ports
//   clk              : clock, all state changes on the rising edge
//   rst              : asynchronous active-high reset (pointers, counts, flags)
//   data_i           : flit to store, target VC = data_i.vc_id
//   write_i          : write strobe
//   read_i           : pop strobe for VC read_vc_i
//   read_vc_i        : VC to pop and to present on data_o
//   clear_err_i      : synchronous clear of the sticky error flags
//   data_o           : head flit of VC read_vc_i
//   is_full_o        : per-VC count == BUFFER_SIZE
//   is_empty_o       : per-VC count == 0
//   is_almost_full_o : per-VC count >= AFULL_THRESHOLD
//   count_o          : per-VC occupancy
//   overflow_o       : sticky, a write was dropped
//   underflow_o      : sticky, a read was ignored
// ---------------------------------------------------------------------------
module vc_circular_buffer
  import vc_circular_buffer_pkg::*;
#(
  parameter int BUFFER_SIZE     = 8,
  parameter int VC_NUM          = 2,
  parameter int AFULL_THRESHOLD = 6,
  localparam int VC_SIZE        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int CNT_W          = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  flit_t                          data_i,
  input  logic                           write_i,
  input  logic                           read_i,
  input  logic [VC_SIZE-1:0]             read_vc_i,
  input  logic                           clear_err_i,
  output flit_t                          data_o,
  output logic [VC_NUM-1:0]              is_full_o,
  output logic [VC_NUM-1:0]              is_empty_o,
  output logic [VC_NUM-1:0]              is_almost_full_o,
  output logic [VC_NUM-1:0][CNT_W-1:0]   count_o,
  output logic                           overflow_o,
  output logic                           underflow_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESHOLD);

  // Per-VC pointer and occupancy state
  logic [PTR_W-1:0] wr_ptr_q [VC_NUM];
  logic [PTR_W-1:0] wr_ptr_d [VC_NUM];
  logic [PTR_W-1:0] rd_ptr_q [VC_NUM];
  logic [PTR_W-1:0] rd_ptr_d [VC_NUM];
  logic [CNT_W-1:0] count_q  [VC_NUM];
  logic [CNT_W-1:0] count_d  [VC_NUM];

  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  // Per-VC request decode and accepted operations
  logic [VC_NUM-1:0] wr_sel;
  logic [VC_NUM-1:0] rd_sel;
  logic [VC_NUM-1:0] wr_en;
  logic [VC_NUM-1:0] rd_en;

  flit_t head_flit [VC_NUM];

  // VC indices are compared at 32 bits so that an out-of-range vc_id
  // (the field is wider than the VC index) matches no VC.
  logic [31:0] wr_vc_ext;
  logic [31:0] rd_vc_ext;
  logic        rd_vc_valid;

  assign wr_vc_ext   = 32'(data_i.vc_id);
  assign rd_vc_ext   = 32'(read_vc_i);
  assign rd_vc_valid = (rd_vc_ext < 32'(VC_NUM));

  // -------------------------------------------------------------------------
  // Per-VC lanes: request decode, storage and status outputs
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc
    flit_t mem [BUFFER_SIZE];

    assign wr_sel[gi] = write_i && (wr_vc_ext == 32'(gi));
    assign rd_sel[gi] = read_i  && (rd_vc_ext == 32'(gi));

    // A pop needs a stored flit. A write to a full VC is still taken when
    // the same cycle pops that VC, because the pop frees the slot.
    // An empty VC is never bypassed: a same-cycle write and read store the
    // flit and ignore the read.
    assign rd_en[gi] = rd_sel[gi] && (count_q[gi] != '0);
    assign wr_en[gi] = wr_sel[gi] && ((count_q[gi] != FULL_CNT) || rd_en[gi]);

    // Storage is not reset; the flit is only meaningful while counted.
    always_ff @(posedge clk) begin
      if (wr_en[gi]) begin
        mem[wr_ptr_q[gi]] <= data_i;
      end
    end

    assign head_flit[gi] = mem[rd_ptr_q[gi]];

    assign count_o[gi]          = count_q[gi];
    assign is_empty_o[gi]       = (count_q[gi] == '0);
    assign is_full_o[gi]        = (count_q[gi] == FULL_CNT);
    assign is_almost_full_o[gi] = (count_q[gi] >= AFULL_CNT);
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      count_d[v]  = count_q[v];

      if (wr_en[v]) begin
        wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(1);
      end
      if (rd_en[v]) begin
        rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(1);
      end

      unique case ({wr_en[v], rd_en[v]})
        2'b10:   count_d[v] = count_q[v] + CNT_W'(1);
        2'b01:   count_d[v] = count_q[v] - CNT_W'(1);
        default: count_d[v] = count_q[v];
      endcase
    end

    // A strobe that no lane accepted is an error. This also covers an
    // out-of-range VC on either side.
    // A new error event overrides a same-cycle clear.
    overflow_d  = (write_i && (wr_en == '0)) || (overflow_q  && !clear_err_i);
    underflow_d = (read_i  && (rd_en == '0)) || (underflow_q && !clear_err_i);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        count_q[v]  <= count_d[v];
      end
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign data_o      = rd_vc_valid ? head_flit[read_vc_i] : '0;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_vc_circular_buffer.sv
// ---------------------------------------------------------------------------
// tb_vc_circular_buffer
//   Directed and random stimulus for vc_circular_buffer with BUFFER_SIZE=8,
//   VC_NUM=2 and AFULL_THRESHOLD=6. Expected values come from two
//   scoreboard queues (one per VC) and two model error flags, updated from
//   the FIFO rules on every clock.
// ---------------------------------------------------------------------------
module tb_vc_circular_buffer;
  import vc_circular_buffer_pkg::*;

  localparam int BS    = 8;
  localparam int NVC   = 2;
  localparam int AF    = 6;
  localparam int CNT_W = $clog2(BS + 1);

  logic                        clk = 1'b0;
  logic                        rst;
  flit_t                       data_i;
  logic                        write_i;
  logic                        read_i;
  logic [0:0]                  read_vc_i;
  logic                        clear_err_i;
  flit_t                       data_o;
  logic [NVC-1:0]              is_full_o;
  logic [NVC-1:0]              is_empty_o;
  logic [NVC-1:0]              is_almost_full_o;
  logic [NVC-1:0][CNT_W-1:0]   count_o;
  logic                        overflow_o;
  logic                        underflow_o;

  vc_circular_buffer #(
    .BUFFER_SIZE    (BS),
    .VC_NUM         (NVC),
    .AFULL_THRESHOLD(AF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_i          (data_i),
    .write_i         (write_i),
    .read_i          (read_i),
    .read_vc_i       (read_vc_i),
    .clear_err_i     (clear_err_i),
    .data_o          (data_o),
    .is_full_o       (is_full_o),
    .is_empty_o      (is_empty_o),
    .is_almost_full_o(is_almost_full_o),
    .count_o         (count_o),
    .overflow_o      (overflow_o),
    .underflow_o     (underflow_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model
  flit_t q0[$];
  flit_t q1[$];
  bit    m_ovf;
  bit    m_unf;

  function automatic int qsize(input int v);
    return (v == 0) ? q0.size() : q1.size();
  endfunction

  function automatic flit_t qhead(input int v);
    return (v == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpush(input int v, input flit_t f);
    if (v == 0) q0.push_back(f);
    else        q1.push_back(f);
  endfunction

  function automatic void qpop(input int v);
    if (v == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic flit_t mk(input logic [1:0] lbl, input logic [1:0] vc,
                               input logic [7:0] d);
    flit_t f;
    f.flit_label = lbl;
    f.vc_id      = vc;
    f.head_data  = d;
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model
  task automatic check_state(input string tag);
    for (int v = 0; v < NVC; v++) begin
      check($sformatf("%s count[%0d]", tag, v), 32'(count_o[v]), 32'(qsize(v)));
      check($sformatf("%s empty[%0d]", tag, v), 32'(is_empty_o[v]), 32'(qsize(v) == 0));
      check($sformatf("%s full[%0d]", tag, v), 32'(is_full_o[v]), 32'(qsize(v) == BS));
      check($sformatf("%s afull[%0d]", tag, v), 32'(is_almost_full_o[v]), 32'(qsize(v) >= AF));
    end
    check({tag, " overflow"}, 32'(overflow_o), 32'(m_ovf));
    check({tag, " underflow"}, 32'(underflow_o), 32'(m_unf));
    if (qsize(int'(read_vc_i)) > 0)
      check({tag, " data_o"}, 32'(data_o), 32'(qhead(int'(read_vc_i))));
  endtask

  // One clock of stimulus with the model update and full state check.
  // Inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic cycle(input string tag, input bit wr, input flit_t f,
                       input bit rd, input logic rvc, input bit clr);
    bit oset;
    bit uset;
    write_i     = wr;
    data_i      = f;
    read_i      = rd;
    read_vc_i   = rvc;
    clear_err_i = clr;
    #1;
    if (rd && qsize(int'(rvc)) > 0)
      check({tag, " pop_head"}, 32'(data_o), 32'(qhead(int'(rvc))));
    @(posedge clk);
    oset = 1'b0;
    uset = 1'b0;
    if (rd) begin
      if (qsize(int'(rvc)) > 0) qpop(int'(rvc));
      else                      uset = 1'b1;
    end
    if (wr) begin
      if (int'(f.vc_id) >= NVC)            oset = 1'b1;
      else if (qsize(int'(f.vc_id)) < BS)  qpush(int'(f.vc_id), f);
      else                                 oset = 1'b1;
    end
    m_ovf = oset | (m_ovf & ~clr);
    m_unf = uset | (m_unf & ~clr);
    #1;
    write_i     = 1'b0;
    read_i      = 1'b0;
    clear_err_i = 1'b0;
    $display("txn %-12s wr=%0b vc=%0d lbl=%0d data=%02h rd=%0b rvc=%0d clr=%0b cnt0=%0d cnt1=%0d ovf=%0b unf=%0b",
             tag, wr, f.vc_id, f.flit_label, f.head_data, rd, rvc, clr,
             count_o[0], count_o[1], overflow_o, underflow_o);
    check_state(tag);
  endtask

  initial begin
    flit_t nf;
    nf          = mk(2'd0, 2'd0, 8'h00);
    rst         = 1'b1;
    write_i     = 1'b0;
    read_i      = 1'b0;
    read_vc_i   = 1'b0;
    clear_err_i = 1'b0;
    data_i      = nf;
    m_ovf       = 1'b0;
    m_unf       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst empty", 32'(is_empty_o), 32'h3);
    check("rst full", 32'(is_full_o), 32'h0);
    check("rst afull", 32'(is_almost_full_o), 32'h0);
    check("rst count", 32'(count_o), 32'h0);
    check("rst ovf", 32'(overflow_o), 32'h0);
    check("rst unf", 32'(underflow_o), 32'h0);
    rst = 1'b0;

    // Fill VC0 with payloads 0..7
    for (int i = 0; i < BS; i++) begin
      cycle("fill0", 1'b1, mk(2'(i), 2'd0, 8'(i)), 1'b0, 1'b0, 1'b0);
      check("fill count0", 32'(count_o[0]), 32'(i + 1));
      check("fill afull0", 32'(is_almost_full_o[0]), 32'(i + 1 >= AF));
      check("fill empty1", 32'(is_empty_o[1]), 32'h1);
    end
    check("fill full0", 32'(is_full_o[0]), 32'h1);

    // Ninth write is dropped
    cycle("over0", 1'b1, mk(2'd1, 2'd0, 8'hEE), 1'b0, 1'b0, 1'b0);
    check("over flag", 32'(overflow_o), 32'h1);
    check("over count", 32'(count_o[0]), 32'(BS));

    // Drain in order
    for (int i = 0; i < BS; i++) begin
      #1;
      check("drain order", 32'(data_o.head_data), 32'(i));
      cycle("drain0", 1'b0, nf, 1'b1, 1'b0, 1'b0);
    end
    check("drain empty0", 32'(is_empty_o[0]), 32'h1);
    cycle("clr", 1'b0, nf, 1'b0, 1'b0, 1'b1);

    // Out-of-range VC is dropped
    cycle("badvc", 1'b1, mk(2'd0, 2'd2, 8'h77), 1'b0, 1'b0, 1'b0);
    check("badvc ovf", 32'(overflow_o), 32'h1);
    check("badvc cnt", 32'(count_o), 32'h0);
    cycle("clr", 1'b0, nf, 1'b0, 1'b0, 1'b1);

    // Full VC0: simultaneous read and write
    for (int i = 0; i < BS; i++)
      cycle("fill0b", 1'b1, mk(2'd1, 2'd0, 8'(8'h10 + i)), 1'b0, 1'b0, 1'b0);
    cycle("rw_full", 1'b1, mk(2'd2, 2'd0, 8'hAA), 1'b1, 1'b0, 1'b0);
    check("rwfull count", 32'(count_o[0]), 32'(BS));
    check("rwfull ovf", 32'(overflow_o), 32'h0);
    for (int i = 0; i < BS; i++) begin
      #1;
      if (i == BS - 1) check("rwfull last", 32'(data_o.head_data), 32'hAA);
      cycle("drain0b", 1'b0, nf, 1'b1, 1'b0, 1'b0);
    end

    // Empty VC1: simultaneous read and write
    cycle("rw_empty", 1'b1, mk(2'd3, 2'd1, 8'h55), 1'b1, 1'b1, 1'b0);
    check("rwempty unf", 32'(underflow_o), 32'h1);
    check("rwempty cnt1", 32'(count_o[1]), 32'h1);
    check("rwempty data", 32'(data_o.head_data), 32'h55);
    cycle("clr", 1'b0, nf, 1'b0, 1'b1, 1'b1);
    check("clr ovf", 32'(overflow_o), 32'h0);
    check("clr unf", 32'(underflow_o), 32'h0);
    cycle("drain1", 1'b0, nf, 1'b1, 1'b1, 1'b0);

    // Error set wins over a same-cycle clear
    cycle("set_clr", 1'b0, nf, 1'b1, 1'b1, 1'b1);
    check("setwins unf", 32'(underflow_o), 32'h1);
    cycle("clr", 1'b0, nf, 1'b0, 1'b0, 1'b1);

    // Random interleaving, checked against the scoreboard each cycle
    for (int i = 0; i < 60; i++) begin
      bit   wr;
      bit   rd;
      logic rvc;
      flit_t f;
      wr  = ($urandom_range(0, 99) < 65);
      rd  = ($urandom_range(0, 99) < 45);
      rvc = 1'($urandom_range(0, 1));
      f   = mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)));
      cycle("rand", wr, f, rd, rvc, ($urandom_range(0, 9) == 0));
    end

    // Drain both VCs
    for (int v = 0; v < NVC; v++) begin
      for (int i = 0; i < BS + 1 && qsize(v) > 0; i++)
        cycle("flush", 1'b0, nf, 1'b1, 1'(v), 1'b0);
    end
    cycle("clr", 1'b0, nf, 1'b0, 1'b0, 1'b1);

    // Async reset between edges
    for (int i = 0; i < 3; i++)
      cycle("pre_rst", 1'b1, mk(2'd0, 2'd0, 8'(8'h30 + i)), 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("arst count", 32'(count_o), 32'h0);
    check("arst empty", 32'(is_empty_o), 32'h3);
    check("arst full", 32'(is_full_o), 32'h0);
    check("arst afull", 32'(is_almost_full_o), 32'h0);
    q0.delete();
    q1.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    rst = 1'b0;
    cycle("post_rst", 1'b1, mk(2'd3, 2'd0, 8'h3C), 1'b0, 1'b0, 1'b0);
    check("postrst data", 32'(data_o), 32'(mk(2'd3, 2'd0, 8'h3C)));
    check("postrst cnt", 32'(count_o[0]), 32'h1);
    cycle("post_pop", 1'b0, nf, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
